mem_stage_ld: RTL
=================

# mem_stage_ld

Parametrised memory-access pipeline stage with a split request/response data-SRAM port. It sits between the execute and write-back stages and holds a load until its response (`data_ok`) returns, buffering read data when write-back stalls. It extracts and sign/zero-extends sub-word loads and exports a forwarding bus that carries the result value and a load-blocking flag. It also supports pipeline flush while a response is still outstanding.

## Interface
Parameters:
- `DATA_WD`, 32, data/GPR width; must be 32 or 64.
- `PC_WD`, 32, PC width.
- `REG_AW`, 5, register-index width.
- `OFF_WD`, derived as `$clog2(DATA_WD/8)`, width of the byte offset.
- `ES_TO_MS_BUS_WD`, derived as `3+OFF_WD+3+REG_AW+DATA_WD+PC_WD`.
- `MS_TO_WS_BUS_WD`, derived as `1+REG_AW+DATA_WD+PC_WD`.
- `MS_TO_DS_BUS_WD`, derived as `2+REG_AW+DATA_WD`.

Ports (`name  direction  width  meaning`):
- `clk  in  1  clock`
- `resetn  in  1  asynchronous, active-low reset`
- `ws_allowin  in  1  write-back can accept`
- `ms_allowin  out  1  this stage can accept`
- `es_to_ms_valid  in  1  EX presents an instruction`
- `es_to_ms_bus  in  ES_TO_MS_BUS_WD  {ld_op[2:0], off, req_sent, res_from_mem, gr_we, dest, alu_result, pc}` (MSB first)
- `ms_to_ws_valid  out  1  result valid to WB`
- `ms_to_ws_bus  out  MS_TO_WS_BUS_WD  {gr_we, dest, final_result, pc}`
- `ms_to_ds_bus  out  MS_TO_DS_BUS_WD  {fwd_valid, fwd_block, dest, final_result}`
- `flush  in  1  discard the in-stage instruction`
- `data_sram_data_ok  in  1  read/write response strobe; one per request`
- `data_sram_rdata  in  DATA_WD  read data, valid with data_ok`

## Operation
- `ld_op` encodings: 0 = W (full width), 1 = B, 2 = BU, 3 = H, 4 = HU. Values 5–7 behave as W.
- Lane selection:
  - Byte lane is `off`.
  - Halfword lane is `off[OFF_WD-1:1]`. `off[0]` is ignored for H/HU.
  - B/H sign-extend; BU/HU zero-extend, all to `DATA_WD`.
- `req_sent`=1 means EX issued a data-SRAM request (load or store) whose response is owed to this stage.
  - `res_from_mem`=1 selects the extracted data; otherwise `alu_result` is selected.
- FSM states:
  - EMPTY: no instruction held.
    - Accept with `req_sent`=1 → WAIT.
    - Accept with `req_sent`=0 → HOLD.
  - WAIT: response owed.
    - `data_ok` → HOLD. Latch `rdata` into `data_buf`.
    - `flush` → DRAIN.
  - HOLD: result ready; `ms_ready_go`=1.
    - Hand-off with no new accept → EMPTY.
    - Hand-off with a new accept → WAIT or HOLD, per the new instruction's `req_sent`.
    - `flush` → EMPTY.
  - DRAIN: instruction discarded, response still owed.
    - `data_ok` → EMPTY. Data is dropped.
- `ms_allowin` = state==EMPTY, or (state==HOLD && `ws_allowin` && !`flush`). It is 0 in WAIT and DRAIN.
- `ms_to_ws_valid` = state==HOLD && !`flush`.
- `final_result` is computed from `data_buf`, never directly from `rdata`.
- Forwarding fields:
  - `fwd_valid` = state∈{WAIT,HOLD} && `gr_we`.
  - `fwd_block` = state==WAIT && `res_from_mem`.
  - When `fwd_valid`=0, `ms_to_ds_bus` is all zeros.
- `flush` has priority over an accept in the same cycle: nothing is latched.
- `data_ok` arriving in EMPTY or HOLD is a protocol error and is ignored.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=EMPTY; bus register and `data_buf` are zeroed.
  - Outputs: `ms_allowin`=1, `ms_to_ws_valid`=0, `ms_to_ds_bus`=0, `ms_to_ws_bus`=0.
- Non-memory instruction: accepted at edge N; `ms_to_ws_valid`=1 in cycle N+1.
- Load: `data_ok` sampled at edge M; `ms_to_ws_valid`=1 from cycle M+1. Minimum latency is one cycle after the response.
- `data_ok` may arrive in the cycle right after accept, or any number of cycles later.
- Back-to-back instructions in HOLD with `ws_allowin`=1 sustain one instruction per cycle.
- When `ws_allowin`=0 in HOLD, outputs and `data_buf` hold stable indefinitely.
- Reset during WAIT or DRAIN returns to EMPTY. Any later response is the SRAM side's responsibility, since it is reset too.

## Structure
- The shared header holds:
  - the `ld_op` encodings;
  - the bus-width macros (`ES_TO_MS_BUS_WD`, `MS_TO_WS_BUS_WD`, `MS_TO_DS_BUS_WD`);
  - the FSM state encodings.
- One sub-module, `load_extract`: purely combinational, inputs (`ld_op`, `off`, `data`), output `DATA_WD` result. It is reused later for unaligned loads.

## Test plan
- Non-memory add, `alu_result`=0x12345678, `ws_allowin`=1 → `ms_to_ws_valid` next cycle; `final_result`=0x12345678; `ms_to_ds_bus` has `fwd_valid`=1 and `fwd_block`=0.
- LB with `off`=2, `rdata`=0x11_80_33_44, `data_ok` 3 cycles after accept:
  - `fwd_block`=1 during WAIT;
  - `ms_allowin`=0 during WAIT;
  - result 0xFFFFFF80 one cycle after `data_ok`.
- LHU with `off`=2, `rdata`=0x8001_7FFF → 0x00008001. LH with `off`=0 on the same data → 0x00007FFF.
- Load whose `data_ok` arrives while `ws_allowin`=0 for 4 cycles → result held stable; one hand-off only; `ms_to_ws_valid` drops the cycle after transfer.
- Sequence:
  1. `flush` during WAIT → DRAIN with `ms_allowin`=0.
  2. `data_ok` arrives with 0xDEAD → no `ms_to_ws_valid`.
  3. Next instruction accepted only after DRAIN exits.
- `resetn` asserted mid-WAIT → immediate EMPTY; all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/mem_stage_ld_pkg.sv
// Shared definitions for the memory-access stage: load-op encodings,
// FSM states and helpers that derive the inter-stage bus widths.
package mem_stage_ld_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_HOLD  = 2'd2,
        MS_DRAIN = 2'd3
    } ms_state_e;

    function automatic int es_to_ms_bus_wd(int data_wd, int pc_wd, int reg_aw);
        return 3 + $clog2(data_wd / 8) + 3 + reg_aw + data_wd + pc_wd;
    endfunction

    function automatic int ms_to_ws_bus_wd(int data_wd, int pc_wd, int reg_aw);
        return 1 + reg_aw + data_wd + pc_wd;
    endfunction

    function automatic int ms_to_ds_bus_wd(int data_wd, int reg_aw);
        return 2 + reg_aw + data_wd;
    endfunction

endpackage

// File: rtl/mem_stage_ld_load_extract.sv
// Combinational sub-word extraction: picks the byte/halfword lane selected
// by the offset and sign- or zero-extends it to the full data width.
module load_extract
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int OFF_WD  = $clog2(DATA_WD / 8)
) (
    input  logic [2:0]         ld_op,
    input  logic [OFF_WD-1:0]  off,
    input  logic [DATA_WD-1:0] data,
    output logic [DATA_WD-1:0] result
);

    logic [DATA_WD-1:0] b_sh;
    logic [DATA_WD-1:0] h_sh;
    logic [7:0]         b;
    logic [15:0]        h;

    // Halfword lane ignores off[0], so the shift uses only the upper offset bits.
    assign b_sh = data >> {off, 3'b000};
    assign h_sh = data >> {off[OFF_WD-1:1], 4'b0000};
    assign b    = b_sh[7:0];
    assign h    = h_sh[15:0];

    always_comb begin
        result = data;
        case (ld_op)
            LD_B:    result = {{(DATA_WD-8){b[7]}}, b};
            LD_BU:   result = {{(DATA_WD-8){1'b0}}, b};
            LD_H:    result = {{(DATA_WD-16){h[15]}}, h};
            LD_HU:   result = {{(DATA_WD-16){1'b0}}, h};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_stage_ld.sv
// Memory-access pipeline stage: holds an instruction until its data-SRAM
// response returns, buffers load data across write-back stalls, forwards results.
module mem_stage_ld
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_WD         = 32,
    parameter int PC_WD           = 32,
    parameter int REG_AW          = 5,
    parameter int OFF_WD          = $clog2(DATA_WD / 8),
    parameter int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(DATA_WD, PC_WD, REG_AW),
    parameter int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(DATA_WD, PC_WD, REG_AW),
    parameter int MS_TO_DS_BUS_WD = ms_to_ds_bus_wd(DATA_WD, REG_AW)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       flush,
    input  logic                       data_sram_data_ok,
    input  logic [DATA_WD-1:0]         data_sram_rdata
);

    localparam int P_ALU  = PC_WD;
    localparam int P_DEST = P_ALU + DATA_WD;
    localparam int P_WE   = P_DEST + REG_AW;
    localparam int P_RFM  = P_WE + 1;
    localparam int P_REQ  = P_RFM + 1;
    localparam int P_OFF  = P_REQ + 1;
    localparam int P_OP   = P_OFF + OFF_WD;

    ms_state_e          state;
    logic [2:0]         ms_ld_op;
    logic [OFF_WD-1:0]  ms_off;
    logic               ms_rfm;
    logic               ms_we;
    logic [REG_AW-1:0]  ms_dest;
    logic [DATA_WD-1:0] ms_alu;
    logic [PC_WD-1:0]   ms_pc;
    logic [DATA_WD-1:0] data_buf;

    logic               accept;
    logic [DATA_WD-1:0] ext_result;
    logic [DATA_WD-1:0] final_result;
    logic               fwd_valid;
    logic               fwd_block;

    assign ms_allowin     = (state == MS_EMPTY) ||
                            (state == MS_HOLD && ws_allowin && !flush);
    assign ms_to_ws_valid = (state == MS_HOLD) && !flush;
    assign accept         = es_to_ms_valid && ms_allowin && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= MS_EMPTY;
            ms_ld_op <= '0;
            ms_off   <= '0;
            ms_rfm   <= 1'b0;
            ms_we    <= 1'b0;
            ms_dest  <= '0;
            ms_alu   <= '0;
            ms_pc    <= '0;
            data_buf <= '0;
        end else if (accept) begin
            ms_ld_op <= es_to_ms_bus[P_OP +: 3];
            ms_off   <= es_to_ms_bus[P_OFF +: OFF_WD];
            ms_rfm   <= es_to_ms_bus[P_RFM];
            ms_we    <= es_to_ms_bus[P_WE];
            ms_dest  <= es_to_ms_bus[P_DEST +: REG_AW];
            ms_alu   <= es_to_ms_bus[P_ALU +: DATA_WD];
            ms_pc    <= es_to_ms_bus[0 +: PC_WD];
            state    <= es_to_ms_bus[P_REQ] ? MS_WAIT : MS_HOLD;
        end else begin
            case (state)
                MS_WAIT: begin
                    // A response coinciding with the flush settles the debt, so no drain is needed.
                    if (flush)
                        state <= data_sram_data_ok ? MS_EMPTY : MS_DRAIN;
                    else if (data_sram_data_ok) begin
                        state    <= MS_HOLD;
                        data_buf <= data_sram_rdata;
                    end
                end
                MS_HOLD: begin
                    if (flush || ws_allowin)
                        state <= MS_EMPTY;
                end
                MS_DRAIN: begin
                    if (data_sram_data_ok)
                        state <= MS_EMPTY;
                end
                default: state <= state;
            endcase
        end
    end

    load_extract #(
        .DATA_WD (DATA_WD),
        .OFF_WD  (OFF_WD)
    ) u_load_extract (
        .ld_op  (ms_ld_op),
        .off    (ms_off),
        .data   (data_buf),
        .result (ext_result)
    );

    assign final_result = ms_rfm ? ext_result : ms_alu;
    assign ms_to_ws_bus = {ms_we, ms_dest, final_result, ms_pc};

    assign fwd_valid    = (state == MS_WAIT || state == MS_HOLD) && ms_we;
    assign fwd_block    = (state == MS_WAIT) && ms_rfm;
    assign ms_to_ds_bus = fwd_valid ? {1'b1, fwd_block, ms_dest, final_result} : '0;

endmodule
